// File: rtl/locked_sec_pkg.sv
// locked_sec_pkg: shared key-FSM state type and SEC code-construction helpers.
package locked_sec_pkg;
    typedef enum logic [1:0] {EMPTY, LOADING, ARMED, DRAIN} key_state_t;

    function automatic int chk_width(input int dw);
        int r = 2;
        while ((1 << r) - r - 1 < dw) r++;
        return r;
    endfunction

    // Data bit j takes the (j+1)-th integer >= 3 that is not a power of two.
    function automatic int code_of(input int j);
        int v = 2;
        int n = -1;
        while (n < j) begin
            v++;
            if ((v & (v - 1)) != 0) n++;
        end
        return v;
    endfunction
endpackage

// File: rtl/sec_syndrome_decode.sv
// sec_syndrome_decode: combinational SEC correction from effective data and syndrome.
module sec_syndrome_decode
    import locked_sec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W = 6
) (
    input  logic [DATA_W-1:0] i_e,
    input  logic [CHK_W-1:0]  i_s,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_err_corr,
    output logic              o_err_unc
);
    logic w_pow;
    logic w_hit;

    assign w_pow = (i_s & (i_s - CHK_W'(1))) == '0;

    always_comb begin
        o_dout = i_e;
        w_hit = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            if (i_s == CHK_W'(code_of(j))) begin
                o_dout[j] = ~i_e[j];
                w_hit = 1'b1;
            end
        end
        o_err_corr = i_s != '0 && (w_pow || w_hit);
        o_err_unc = i_s != '0 && !w_pow && !w_hit;
    end
endmodule

// File: rtl/locked_sec_pipe.sv
// locked_sec_pipe: two-stage key-locked SEC decoder with serial key load and valid/ready flow.
module locked_sec_pipe
    import locked_sec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEY_W = 16,
    parameter logic [KEY_W-1:0] KEY_INV = '0,
    localparam int CHK_W = chk_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_valid,
    input  logic              key_bit,
    output logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [CHK_W-1:0]  chk_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic              err_corr,
    output logic              err_unc
);
    localparam int CW = $clog2(KEY_W + 1);

    key_state_t        r_state, w_next;
    logic [KEY_W-1:0]  r_key;
    logic [CW-1:0]     r_cnt;
    logic              r_v1, r_v2, w_empty, w_adv2, w_acc;
    logic [DATA_W-1:0] w_e, r_e1, w_dout, r_dout;
    logic [CHK_W-1:0]  w_s, r_s1;
    logic              w_corr, w_unc, r_corr, r_unc;

    always_comb begin
        w_e = din;
        for (int k = 0; k < KEY_W; k++)
            w_e[(k * DATA_W) / KEY_W] = din[(k * DATA_W) / KEY_W] ^ r_key[k] ^ KEY_INV[k];
        w_s = chk_in;
        for (int j = 0; j < DATA_W; j++)
            if (w_e[j]) w_s = w_s ^ CHK_W'(code_of(j));
    end

    assign w_empty   = !r_v1 && !r_v2;
    assign w_adv2    = !r_v2 || out_ready;
    assign key_ready = r_state == LOADING;
    assign in_ready  = r_state == ARMED && !key_start && (w_adv2 || !r_v1);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = r_v2;
    assign dout      = r_dout;
    assign err_corr  = r_corr;
    assign err_unc   = r_unc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   if (key_start) w_next = LOADING;
            LOADING: if (!key_start && key_valid && r_cnt == CW'(KEY_W - 1)) w_next = ARMED;
            ARMED:   if (key_start) w_next = w_empty ? LOADING : DRAIN;
            default: if (w_empty) w_next = LOADING;
        endcase
    end

    sec_syndrome_decode #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_dec (
        .i_e(r_e1),
        .i_s(r_s1),
        .o_dout(w_dout),
        .o_err_corr(w_corr),
        .o_err_unc(w_unc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_key   <= '0;
            r_cnt   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_e1    <= '0;
            r_s1    <= '0;
            r_dout  <= '0;
            r_corr  <= 1'b0;
            r_unc   <= 1'b0;
        end else begin
            r_state <= w_next;
            // A restart or any exit from LOADING leaves the beat counter at zero.
            r_cnt <= (w_next != LOADING || key_start) ? '0 : r_cnt + CW'(key_valid);
            for (int k = 0; k < KEY_W; k++)
                if (r_state == LOADING && !key_start && key_valid && r_cnt == CW'(k)) r_key[k] <= key_bit;
            if (!r_v1 || w_adv2) begin
                r_v1 <= w_acc;
                if (w_acc) begin
                    r_e1 <= w_e;
                    r_s1 <= w_s;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dout <= w_dout;
                    r_corr <= w_corr;
                    r_unc  <= w_unc;
                end
            end
        end
    end
endmodule
